sat_engine_ctrl: RTL and testbench

Top-level sequencer for the Sat Engine variable-state datapath, i.e. the array of 8-variable state blocks.
It drives the decide → imply → analyze → backtrack loop:
- loads variable states;
- picks decision variables;
- iterates implication until a fixed point or a conflict;
- backtracks on conflict and reports SAT, UNSAT or error.
It sits between the engine's host interface and the variable/clause datapath.

---
 rtl/sat_engine_ctrl.sv | 159 +++++++++++++++
 tb/tb_sat_engine_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sat_engine_ctrl.sv
// Sequencer for the Sat Engine variable-state datapath: load, decide, imply,
// analyze and backtrack until SAT, UNSAT or an abort condition.
module sat_engine_ctrl #(
    parameter int unsigned NUM_VARS        = 8,
    parameter int unsigned WIDTH_LVL       = 10,
    parameter int unsigned MAX_IMPLY_ITERS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  done_o,
    output logic                  sat_o,
    output logic                  unsat_o,
    output logic                  err_o,
    output logic [NUM_VARS-1:0]   wr_states_o,
    input  logic [NUM_VARS*3-1:0] var_value_i,
    output logic [NUM_VARS-1:0]   index_decided_o,
    output logic [WIDTH_LVL-1:0]  cur_lvl_o,
    output logic                  apply_imply_o,
    input  logic                  find_imply_i,
    input  logic                  find_conflict_i,
    output logic                  apply_analyze_o,
    input  logic [WIDTH_LVL-1:0]  max_lvl_i,
    output logic                  apply_bkt_o,
    output logic [WIDTH_LVL-1:0]  bkt_lvl_o
);

    localparam int unsigned CNT_W = $clog2(MAX_IMPLY_ITERS + 1);
    localparam logic [CNT_W-1:0] IMPLY_LIMIT = CNT_W'(MAX_IMPLY_ITERS);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_IMPLY, S_IMPLY_WAIT, S_DECIDE,
        S_ANALYZE, S_ANALYZE_WAIT, S_BKT, S_DONE
    } state_t;

    state_t               r_state, w_state_next;
    logic [CNT_W-1:0]     r_imply_cnt;
    logic [WIDTH_LVL-1:0] r_cur_lvl, r_bkt_lvl, w_bkt;
    logic [NUM_VARS-1:0]  r_wr_states, r_index_decided, w_onehot;
    logic                 r_done, r_sat, r_unsat, r_err;
    logic                 r_apply_imply, r_apply_analyze, r_apply_bkt;
    logic                 w_any_free, w_set_sat, w_set_unsat, w_set_err;

    // Lowest-index unassigned variable wins
    always_comb begin
        w_any_free = 1'b0;
        w_onehot   = '0;
        for (int unsigned i = 0; i < NUM_VARS; i++) begin
            if (!w_any_free && var_value_i[3*i +: 3] == 3'b000) begin
                w_any_free  = 1'b1;
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_bkt = (max_lvl_i < r_cur_lvl) ? max_lvl_i : r_cur_lvl - 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:         if (start_i) w_state_next = S_LOAD;
            S_LOAD:         w_state_next = S_IMPLY;
            S_IMPLY:        w_state_next = S_IMPLY_WAIT;
            S_IMPLY_WAIT: begin
                if (find_conflict_i)
                    w_state_next = (r_cur_lvl == '0) ? S_DONE : S_ANALYZE;
                else if (find_imply_i)
                    w_state_next = (r_imply_cnt == IMPLY_LIMIT) ? S_DONE : S_IMPLY;
                else
                    w_state_next = S_DECIDE;
            end
            S_DECIDE:       w_state_next = (!w_any_free || &r_cur_lvl) ? S_DONE : S_IMPLY;
            S_ANALYZE:      w_state_next = S_ANALYZE_WAIT;
            S_ANALYZE_WAIT: w_state_next = S_BKT;
            S_BKT:          w_state_next = S_IMPLY;
            S_DONE:         w_state_next = S_IDLE;
            default:        w_state_next = S_IDLE;
        endcase
    end

    // Output/result decode; strobes are registered so they line up with the state they belong to
    always_comb begin
        w_set_sat   = (r_state == S_DECIDE) && !w_any_free;
        w_set_unsat = (r_state == S_IMPLY_WAIT) && find_conflict_i && (r_cur_lvl == '0);
        w_set_err   = ((r_state == S_IMPLY_WAIT) && !find_conflict_i && find_imply_i
                       && (r_imply_cnt == IMPLY_LIMIT))
                   || ((r_state == S_DECIDE) && w_any_free && (&r_cur_lvl));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_imply_cnt     <= '0;
            r_cur_lvl       <= '0;
            r_bkt_lvl       <= '0;
            r_wr_states     <= '0;
            r_index_decided <= '0;
            r_apply_imply   <= 1'b0;
            r_apply_analyze <= 1'b0;
            r_apply_bkt     <= 1'b0;
            r_done          <= 1'b0;
            r_sat           <= 1'b0;
            r_unsat         <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_wr_states     <= (w_state_next == S_LOAD) ? '1 : '0;
            r_apply_imply   <= (w_state_next == S_IMPLY);
            r_apply_analyze <= (w_state_next == S_ANALYZE);
            r_apply_bkt     <= (w_state_next == S_BKT);
            r_done          <= (w_state_next == S_DONE);
            r_index_decided <= (r_state == S_DECIDE && w_state_next == S_IMPLY) ? w_onehot : '0;
            r_bkt_lvl       <= (w_state_next == S_BKT) ? w_bkt : '0;

            if (r_state == S_IDLE && start_i) begin
                r_cur_lvl   <= '0;
                r_imply_cnt <= '0;
                r_sat       <= 1'b0;
                r_unsat     <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                if (r_state == S_DECIDE && w_state_next == S_IMPLY)
                    r_cur_lvl <= r_cur_lvl + 1'b1;
                else if (r_state == S_ANALYZE_WAIT)
                    r_cur_lvl <= w_bkt;

                if (r_state == S_IMPLY)
                    r_imply_cnt <= r_imply_cnt + 1'b1;
                else if ((r_state == S_IMPLY_WAIT && w_state_next == S_DECIDE)
                         || r_state == S_ANALYZE_WAIT)
                    r_imply_cnt <= '0;

                if (w_set_sat)   r_sat   <= 1'b1;
                if (w_set_unsat) r_unsat <= 1'b1;
                if (w_set_err)   r_err   <= 1'b1;
            end
        end
    end

    assign done_o          = r_done;
    assign sat_o           = r_sat;
    assign unsat_o         = r_unsat;
    assign err_o           = r_err;
    assign wr_states_o     = r_wr_states;
    assign index_decided_o = r_index_decided;
    assign cur_lvl_o       = r_cur_lvl;
    assign apply_imply_o   = r_apply_imply;
    assign apply_analyze_o = r_apply_analyze;
    assign apply_bkt_o     = r_apply_bkt;
    assign bkt_lvl_o       = r_bkt_lvl;

endmodule

// File: tb/tb_sat_engine_ctrl.sv
// Directed bench for sat_engine_ctrl: drives the datapath flags by hand and
// checks the sequencer's strobes, levels and result flags step by step.
module tb_sat_engine_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        done_o, sat_o, unsat_o, err_o;
    logic [7:0]  wr_states_o, index_decided_o;
    logic [23:0] var_value_i;
    logic [9:0]  cur_lvl_o, max_lvl_i, bkt_lvl_o;
    logic        apply_imply_o, find_imply_i, find_conflict_i;
    logic        apply_analyze_o, apply_bkt_o;

    int n_tests = 0;
    int n_fail  = 0;

    int mon_done = 0, mon_imply = 0, mon_analyze = 0, mon_idx = 0;

    localparam logic [23:0] ALL_ASSIGNED = 24'h249249;
    localparam logic [23:0] VARS01_ONLY  = 24'h000009;

    sat_engine_ctrl #(
        .NUM_VARS(8),
        .WIDTH_LVL(10),
        .MAX_IMPLY_ITERS(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .done_o(done_o),
        .sat_o(sat_o),
        .unsat_o(unsat_o),
        .err_o(err_o),
        .wr_states_o(wr_states_o),
        .var_value_i(var_value_i),
        .index_decided_o(index_decided_o),
        .cur_lvl_o(cur_lvl_o),
        .apply_imply_o(apply_imply_o),
        .find_imply_i(find_imply_i),
        .find_conflict_i(find_conflict_i),
        .apply_analyze_o(apply_analyze_o),
        .max_lvl_i(max_lvl_i),
        .apply_bkt_o(apply_bkt_o),
        .bkt_lvl_o(bkt_lvl_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_o)          mon_done++;
        if (apply_imply_o)   mon_imply++;
        if (apply_analyze_o) mon_analyze++;
        if (index_decided_o != 8'h00) mon_idx++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {21'd0, done_o, sat_o, unsat_o, err_o, wr_states_o, index_decided_o,
                cur_lvl_o, apply_imply_o, apply_analyze_o, apply_bkt_o, bkt_lvl_o};
    endfunction

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        int base_done, base_imply, base_analyze, base_idx;
        bit seen;

        rst = 1'b1; start_i = 1'b0; var_value_i = ALL_ASSIGNED;
        find_imply_i = 1'b0; find_conflict_i = 1'b0; max_lvl_i = '0;
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 64'h0);
        rst = 1'b0;
        tick();

        // Trivial SAT: done 5 cycles after start
        base_idx = mon_idx;
        pulse_start();
        chk("load_wr_states", 64'(wr_states_o), 64'hFF);
        tick();
        chk("first_imply", 64'(apply_imply_o), 64'h1);
        chk("wr_states_single", 64'(wr_states_o), 64'h0);
        tick(); tick();
        chk("sat_not_early", 64'(done_o), 64'h0);
        tick();
        chk("sat_done_at_5", 64'({done_o, sat_o, unsat_o, err_o}), 64'b1100);
        tick();
        chk("sat_held", 64'({done_o, sat_o, unsat_o, err_o}), 64'b0100);
        chk("sat_no_decision", 64'(mon_idx - base_idx), 64'h0);

        // Decide order and level climb
        var_value_i = VARS01_ONLY;
        pulse_start();
        chk("start_clears_sat", 64'(sat_o), 64'h0);
        tick(); tick(); tick(); tick();
        chk("decide_onehot", 64'(index_decided_o), 64'h04);
        chk("decide_lvl1", 64'(cur_lvl_o), 64'h1);
        chk("decide_then_imply", 64'(apply_imply_o), 64'h1);
        repeat (6) tick();
        chk("climb_lvl3", 64'(cur_lvl_o), 64'h3);

        // Conflict at level 3, learnt max level 1
        find_conflict_i = 1'b1; max_lvl_i = 10'd1;
        tick();
        tick();
        find_conflict_i = 1'b0;
        chk("analyze_pulse", 64'(apply_analyze_o), 64'h1);
        tick();
        chk("analyze_single", 64'(apply_analyze_o), 64'h0);
        tick();
        chk("bkt_to_1", 64'({apply_bkt_o, bkt_lvl_o, cur_lvl_o}), {43'd0, 1'b1, 10'd1, 10'd1});
        tick();
        chk("imply_after_bkt", 64'({apply_imply_o, apply_bkt_o, bkt_lvl_o}), {53'd0, 1'b1, 1'b0, 10'd0});
        repeat (6) tick();
        chk("reclimb_lvl3", 64'(cur_lvl_o), 64'h3);

        // Conflict at level 3, learnt max level 3 -> cur_lvl-1
        find_conflict_i = 1'b1; max_lvl_i = 10'd3;
        tick(); tick();
        find_conflict_i = 1'b0;
        tick(); tick();
        chk("bkt_to_2", 64'({apply_bkt_o, bkt_lvl_o, cur_lvl_o}), {43'd0, 1'b1, 10'd2, 10'd2});
        var_value_i = ALL_ASSIGNED;
        tick(); tick(); tick(); tick();
        chk("bkt_solve_sat", 64'({done_o, sat_o, unsat_o, err_o}), 64'b1100);
        tick();

        // Level-0 conflict -> UNSAT without analysis
        base_analyze = mon_analyze;
        pulse_start();
        tick();
        find_conflict_i = 1'b1;
        tick(); tick();
        find_conflict_i = 1'b0;
        chk("unsat_done", 64'({done_o, sat_o, unsat_o, err_o}), 64'b1010);
        tick();
        chk("unsat_no_analyze", 64'(mon_analyze - base_analyze), 64'h0);

        // Imply limit with a stray start while busy
        find_imply_i = 1'b1;
        base_imply = mon_imply;
        base_done  = mon_done;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            start_i = (i == 10);
            tick();
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
        find_imply_i = 1'b0;
        chk("limit_done_seen", 64'(seen), 64'h1);
        chk("limit_err", 64'({sat_o, unsat_o, err_o}), 64'b001);
        chk("limit_imply_count", 64'(mon_imply - base_imply), 64'd32);
        tick();
        chk("limit_single_done", 64'(mon_done - base_done), 64'd1);
        chk("limit_back_idle", 64'(apply_imply_o), 64'h0);

        // Reset mid-IMPLY aborts without done
        base_done = mon_done;
        pulse_start();
        tick();
        chk("pre_reset_imply", 64'(apply_imply_o), 64'h1);
        rst = 1'b1;
        repeat (3) tick();
        chk("midsolve_reset_outs", all_outs(), 64'h0);
        rst = 1'b0;
        repeat (4) tick();
        chk("midsolve_no_done", 64'(mon_done - base_done), 64'h0);

        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("post_reset_done", 64'(seen), 64'h1);
        chk("post_reset_sat", 64'({sat_o, unsat_o, err_o}), 64'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
